// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - signed 8-bit result to 4-digit multiplexed 7-segment display driver
// Optional feature macro: HEX_MODE_EN (raw two-digit hex display, conversion bypassed)
`timescale 1ns/1ps

module result_display_driver #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value_in,
    input  logic       load,
`ifdef HEX_MODE_EN
    input  logic       hex_mode,
`endif
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             sign_q, sign_d;
    logic [19:0]      bcd_q, bcd_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0][6:0]  disp_q, disp_d;
    logic [RW-1:0]    ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       mag;
`ifdef HEX_MODE_EN
    logic             hex_q, hex_d;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
`ifdef HEX_MODE_EN
            4'd10:   p = 7'b0001000;
            4'd11:   p = 7'b0000011;
            4'd12:   p = 7'b1000110;
            4'd13:   p = 7'b0100001;
            4'd14:   p = 7'b0000110;
            4'd15:   p = 7'b0001110;
`endif
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // One double-dabble iteration over the 3 BCD nibbles sitting above the 8 binary bits.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5) begin
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // 8-bit negation is enough: -128 wraps to 8'h80, which read unsigned is 128.
    assign mag = value_in[7] ? (8'd0 - value_in) : value_in;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
`ifdef HEX_MODE_EN
        hex_d   = hex_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    sign_d  = value_in[7];
                    bcd_d   = {12'b0, mag};
                    cnt_d   = 3'd0;
                    state_d = CONV;
`ifdef HEX_MODE_EN
                    hex_d = hex_mode;
                    if (hex_mode) begin
                        bcd_d   = {12'b0, value_in};
                        state_d = COMMIT;
                    end
`endif
                end
            end
            CONV: begin
                bcd_d = dabble_step(bcd_q);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
`ifdef HEX_MODE_EN
                if (hex_q) begin
                    disp_d = {SEG_BLANK, SEG_BLANK,
                              seg_decode(bcd_q[7:4]), seg_decode(bcd_q[3:0])};
                end else
`endif
                begin
                    disp_d[3] = sign_q ? SEG_MINUS : SEG_BLANK;
                    disp_d[2] = (bcd_q[19:16] == 4'd0) ? SEG_BLANK : seg_decode(bcd_q[19:16]);
                    disp_d[1] = ((bcd_q[19:16] == 4'd0) && (bcd_q[15:12] == 4'd0))
                                ? SEG_BLANK : seg_decode(bcd_q[15:12]);
                    disp_d[0] = seg_decode(bcd_q[11:8]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan path is free-running and only ever reads committed display registers.
    always_comb begin
        ref_d = ref_q + RW'(1);
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = disp_q[idx_q];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
            ref_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
`ifdef HEX_MODE_EN
            hex_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
`ifdef HEX_MODE_EN
            hex_q   <= hex_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_result_display_driver.sv
// tb/tb_result_display_driver.sv - directed self-checking bench for result_display_driver
`timescale 1ns/1ps

module tb_result_display_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] value_in = 8'd0;
    logic       load = 1'b0;
`ifdef HEX_MODE_EN
    logic       hex_mode = 1'b0;
`endif
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [6:0] BL = 7'h7F;

    always #5 clock = ~clock;

    result_display_driver #(.REFRESH_CYCLES(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
`ifdef HEX_MODE_EN
        .hex_mode (hex_mode),
`endif
        .busy     (busy),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    // Watches one full scan and records each digit's segments, digit3 in the top bits.
    task automatic capture(output logic [27:0] segs, output logic [3:0] seen);
        segs = '1;
        seen = 4'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            case (an)
                4'b1110: begin segs[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin segs[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin segs[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin segs[27:21] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic start_load(input logic [7:0] v);
        @(negedge clock);
        value_in = v;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #2;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec_cnt++; if (an !== 4'b1111) begin err_cnt++; $display("FAIL reset_an: got %b expected 1111", an); end
        vec_cnt++; if (seg !== BL) begin err_cnt++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
        vec_cnt++; if (dp !== 1'b1) begin err_cnt++; $display("FAIL reset_dp: got %b expected 1", dp); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_scan;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        one = 4'b0001;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            exp_an  = ~(one << (i / 4));
            exp_seg = (i / 4 == 0) ? 7'b1000000 : BL;
            vec_cnt++;
            if (an !== exp_an) begin
                err_cnt++; $display("FAIL scan_an[%0d]: got %b expected %b", i, an, exp_an);
            end
            vec_cnt++;
            if (seg !== exp_seg) begin
                err_cnt++; $display("FAIL scan_seg[%0d]: got %b expected %b", i, seg, exp_seg);
            end
        end
    endtask

    task automatic test_decimal_42;
        int n;
        logic [27:0] segs;
        logic [3:0] seen;
        start_load(8'd42);
        count_busy(n);
        vec_cnt++; if (n != 9) begin err_cnt++; $display("FAIL busy_cycles_42: got %0d expected 9", n); end
        repeat (2) @(negedge clock);
        capture(segs, seen);
        vec_cnt++; if (seen !== 4'hF) begin err_cnt++; $display("FAIL scan_seen_42: got %b expected 1111", seen); end
        vec_cnt++;
        if (segs !== {BL, BL, 7'b0011001, 7'b0100100}) begin
            err_cnt++; $display("FAIL display_42: got %h expected %h", segs, {BL, BL, 7'b0011001, 7'b0100100});
        end
    endtask

    task automatic test_negative;
        int n;
        logic [27:0] segs;
        logic [3:0] seen;
        start_load(8'h80);
        count_busy(n);
        vec_cnt++; if (n != 9) begin err_cnt++; $display("FAIL busy_cycles_m128: got %0d expected 9", n); end
        repeat (2) @(negedge clock);
        capture(segs, seen);
        vec_cnt++;
        if (segs !== {7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000}) begin
            err_cnt++; $display("FAIL display_m128: got %h expected %h", segs,
                                {7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000});
        end
        start_load(8'hFB);
        count_busy(n);
        vec_cnt++; if (n != 9) begin err_cnt++; $display("FAIL busy_cycles_m5: got %0d expected 9", n); end
        repeat (2) @(negedge clock);
        capture(segs, seen);
        vec_cnt++;
        if (segs !== {7'b0111111, BL, BL, 7'b0010010}) begin
            err_cnt++; $display("FAIL display_m5: got %h expected %h", segs, {7'b0111111, BL, BL, 7'b0010010});
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [27:0] segs;
        logic [3:0] seen;
        start_load(8'd7);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin value_in = 8'd99; load = 1'b1; end
            if (n == 3) load = 1'b0;
            @(negedge clock);
        end
        load = 1'b0;
        vec_cnt++; if (n != 9) begin err_cnt++; $display("FAIL busy_cycles_b2b: got %0d expected 9", n); end
        repeat (3) @(negedge clock);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_no_queue: busy got %b expected 0", busy); end
        capture(segs, seen);
        vec_cnt++;
        if (segs !== {BL, BL, BL, 7'b1111000}) begin
            err_cnt++; $display("FAIL display_b2b: got %h expected %h", segs, {BL, BL, BL, 7'b1111000});
        end
    endtask

    task automatic test_reset_mid_conv;
        logic [27:0] segs;
        logic [3:0] seen;
        start_load(8'd100);
        repeat (3) @(negedge clock);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midconv_busy_pre: got %b expected 1", busy); end
        #1 reset = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midconv_busy: got %b expected 0", busy); end
        vec_cnt++; if (an !== 4'b1111) begin err_cnt++; $display("FAIL midconv_an: got %b expected 1111", an); end
        vec_cnt++; if (seg !== BL) begin err_cnt++; $display("FAIL midconv_seg: got %b expected 1111111", seg); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midconv_busy_post: got %b expected 0", busy); end
        capture(segs, seen);
        vec_cnt++;
        if (segs !== {BL, BL, BL, 7'b1000000}) begin
            err_cnt++; $display("FAIL display_after_reset: got %h expected %h", segs, {BL, BL, BL, 7'b1000000});
        end
    endtask

`ifdef HEX_MODE_EN
    task automatic test_hex;
        int n;
        logic [27:0] segs;
        logic [3:0] seen;
        hex_mode = 1'b1;
        start_load(8'hA5);
        hex_mode = 1'b0;
        count_busy(n);
        vec_cnt++; if (n != 1) begin err_cnt++; $display("FAIL busy_cycles_hex: got %0d expected 1", n); end
        repeat (2) @(negedge clock);
        capture(segs, seen);
        vec_cnt++;
        if (segs !== {BL, BL, 7'b0001000, 7'b0010010}) begin
            err_cnt++; $display("FAIL display_hex: got %h expected %h", segs, {BL, BL, 7'b0001000, 7'b0010010});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_decimal_42();
        test_negative();
        test_back_to_back();
        test_reset_mid_conv();
`ifdef HEX_MODE_EN
        test_hex();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
